// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, registers fetched words for decode, handles redirects and halt.
// Optional `FETCH_COUNT_EN adds a saturating Fetch_Count of decode handshakes.
module fetch_controller #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]        HALT_OPCODE = 6'h3F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    output logic [ADDR_W-1:0] Read_Address,
    input  logic [DATA_W-1:0] Instruction,
    output logic [DATA_W-1:0] Inst_Out,
    output logic [ADDR_W-1:0] Inst_PC,
    output logic              Inst_Valid,
    input  logic              Inst_Ready,
    input  logic              Redirect,
    input  logic              Redirect_Mode,
    input  logic [ADDR_W-1:0] Redirect_Target,
    output logic              Halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]       Fetch_Count
`endif
);

    localparam int unsigned OPC_LSB = DATA_W - 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   inst_out_d;
    logic [ADDR_W-1:0]   inst_pc_d;
    logic                valid_d;
    logic                halted_d;

    logic                load_ok;
    logic                handshake;
    logic                is_halt;
    logic [ADDR_W-1:0]   redirect_pc;

    assign Read_Address = pc_q;
    assign load_ok      = !Inst_Valid || Inst_Ready;
    assign handshake    = Inst_Valid && Inst_Ready;
    assign is_halt      = (Instruction[DATA_W-1:OPC_LSB] == HALT_OPCODE);
    // Same-width modular add makes sign extension of the offset implicit.
    assign redirect_pc  = Redirect_Mode ? Redirect_Target
                                        : Inst_PC + ADDR_W'(1) + Redirect_Target;

    // Next-state and next-register computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_out_d = Inst_Out;
        inst_pc_d  = Inst_PC;
        valid_d    = Inst_Valid;
        halted_d   = Halted;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (Start) begin
                    pc_d    = RESET_PC;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (Redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                end else if (load_ok) begin
                    inst_out_d = Instruction;
                    inst_pc_d  = pc_q;
                    valid_d    = 1'b1;
                    if (is_halt) begin
                        state_d = S_DRAIN;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (Redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                    state_d = S_RUN;
                end else if (handshake) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
                if (Start) begin
                    halted_d = 1'b0;
                    pc_d     = RESET_PC;
                    state_d  = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            Inst_Out   <= '0;
            Inst_PC    <= '0;
            Inst_Valid <= 1'b0;
            Halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            Inst_Out   <= inst_out_d;
            Inst_PC    <= inst_pc_d;
            Inst_Valid <= valid_d;
            Halted     <= halted_d;
        end
    end

`ifdef FETCH_COUNT_EN
    localparam int unsigned CNT_W = 16;

    logic start_ok;
    assign start_ok = Start && ((state_q == S_IDLE) || (state_q == S_HALT));

    // Saturating count of words accepted by decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Fetch_Count <= '0;
        end else if (start_ok) begin
            Fetch_Count <= '0;
        end else if (handshake && (Fetch_Count != {CNT_W{1'b1}})) begin
            Fetch_Count <= Fetch_Count + CNT_W'(1);
        end
    end
`endif

endmodule
